// File: rtl/instr_issue_unit.sv
// Instruction fetch/issue sequencer: reads 16-bit words from synchronous
// instruction memory and presents them to the control unit under valid/ready.
`timescale 1ns/1ps

module instr_issue_unit #(
    parameter int unsigned   AW       = 8,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter logic [3:0]    HALT_OP  = 4'b1110
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic [15:0]   imem_rdata,
    output logic          issue_valid,
    input  logic          issue_ready,
    output logic [15:0]   instr,
    output logic [3:0]    opcode,
    output logic [2:0]    funct,
    output logic [AW-1:0] pc,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    input  logic          resume,
    output logic          halted,
    output logic [15:0]   retired
);

    localparam int unsigned IW = 16;
    localparam int unsigned CW = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        ISSUE = 3'd3,
        HALT  = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [IW-1:0]   instr_q, instr_d;
    logic [CW-1:0]   retired_q, retired_d;
    logic            imem_req_q, imem_req_d;
    logic            issue_valid_q, issue_valid_d;
    logic            halted_q, halted_d;

    // Next-state, datapath update and registered-output decode
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                instr_d = imem_rdata;
                state_d = ISSUE;
            end
            ISSUE: begin
                if (issue_valid_q && issue_ready) begin
                    retired_d = retired_q + CW'(1);
                    if (instr_q[15:12] == HALT_OP) begin
                        state_d = HALT;
                    end else if (redirect_valid) begin
                        pc_d    = redirect_pc;
                        state_d = FETCH;
                    end else begin
                        pc_d    = pc_q + AW'(1);
                        state_d = FETCH;
                    end
                end
            end
            HALT: begin
                if (resume) begin
                    pc_d    = pc_q + AW'(1);
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are pure functions of the upcoming state
        imem_req_d    = (state_d == FETCH);
        issue_valid_d = (state_d == ISSUE);
        halted_d      = (state_d == HALT);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            retired_q     <= '0;
            imem_req_q    <= 1'b0;
            issue_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            retired_q     <= retired_d;
            imem_req_q    <= imem_req_d;
            issue_valid_q <= issue_valid_d;
            halted_q      <= halted_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign issue_valid = issue_valid_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[15:12];
    assign funct       = instr_q[2:0];
    assign pc          = pc_q;
    assign halted      = halted_q;
    assign retired     = retired_q;

endmodule
